bht_fetch_predictor: RTL and testbench

Parametrised PC-select unit for the LC-3b fetch stage. It generalises static fetch steering with a branch history table of saturating counters, so conditional BRs are predicted taken or not-taken at fetch. The table is trained when the branch resolves downstream. The block flags mispredictions and keeps performance counters. It sits between fetch predecode (opcode/nzp of the fetched word) and the pcmux, and takes resolution data from the stage that evaluates CC.

---
 rtl/bht_fetch_predictor.sv | 154 +++++++++++++++
 tb/tb_bht_fetch_predictor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_fetch_predictor.sv
// rtl/bht_fetch_predictor.sv - fetch-stage PC select with a saturating-counter branch history table
module bht_fetch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              predict_en,
    input  logic              f_valid,
    input  logic [PC_W-1:0]   f_pc,
    input  logic [3:0]        f_opcode,
    input  logic [2:0]        f_ir_9_11,
    output logic [1:0]        f_sel,
    output logic              f_pred_taken,
    input  logic              r_valid,
    input  logic [PC_W-1:0]   r_pc,
    input  logic [2:0]        r_ir_9_11,
    input  logic [2:0]        r_cc,
    input  logic              r_pred_taken,
    output logic              r_actual_taken,
    output logic              r_mispredict,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam int INDEX_W = $clog2(ENTRIES);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] SEL_PC2    = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;
    localparam logic [1:0] SEL_JMP    = 2'b11;

    // Weakly not-taken: MSB clear, every lower bit set.
    localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_MIN  = {CTR_W{1'b0}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0]   table_q [ENTRIES];

    logic [INDEX_W-1:0] f_idx;
    logic [INDEX_W-1:0] r_idx;
    logic [CTR_W-1:0]   f_ctr;
    logic [CTR_W-1:0]   r_ctr;
    logic [CTR_W-1:0]   r_ctr_next;
    logic               f_is_br;
    logic               r_trainable;
    logic               train_en;
    logic               actual_taken;
    logic               mispredict;

    // The PC is word-aligned, so bit 0 never carries index information.
    assign f_idx = f_pc[INDEX_W:1];
    assign r_idx = r_pc[INDEX_W:1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[PC_W-1:INDEX_W+1], f_pc[0], r_pc[PC_W-1:INDEX_W+1], r_pc[0]};

    assign f_ctr = table_q[f_idx];
    assign r_ctr = table_q[r_idx];

    assign f_is_br = f_valid && (f_opcode == OP_BR);

    // Fetch-side prediction: unconditional and never-taken encodings are static, the rest read the table.
    always_comb begin
        f_pred_taken = 1'b0;
        if (f_is_br) begin
            if (f_ir_9_11 == 3'b111) begin
                f_pred_taken = 1'b1;
            end else if (f_ir_9_11 == 3'b000) begin
                f_pred_taken = 1'b0;
            end else begin
                f_pred_taken = predict_en && f_ctr[CTR_W-1];
            end
        end
    end

    // Pcmux steering from predecoded opcode and the BR prediction.
    always_comb begin
        f_sel = SEL_PC2;
        if (f_valid) begin
            unique case (f_opcode)
                OP_BR:   f_sel = f_pred_taken ? SEL_TARGET : SEL_PC2;
                OP_TRAP: f_sel = SEL_TRAP;
                OP_JMP:  f_sel = SEL_JMP;
                default: f_sel = SEL_PC2;
            endcase
        end
    end

    // Resolution outcome and flush request for the pipeline.
    always_comb begin
        actual_taken = r_valid && (|(r_ir_9_11 & r_cc));
        mispredict   = r_valid && (actual_taken != r_pred_taken);
    end

    assign r_actual_taken = actual_taken;
    assign r_mispredict   = mispredict;

    // Only conditional BRs carry information worth learning.
    assign r_trainable = (r_ir_9_11 != 3'b000) && (r_ir_9_11 != 3'b111);
    assign train_en    = r_valid && r_trainable;

    // Saturating step of the resolving entry's counter toward the actual outcome.
    always_comb begin
        r_ctr_next = r_ctr;
        if (actual_taken) begin
            if (r_ctr != CTR_MAX) begin
                r_ctr_next = r_ctr + CTR_W'(1);
            end
        end else begin
            if (r_ctr != CTR_MIN) begin
                r_ctr_next = r_ctr - CTR_W'(1);
            end
        end
    end

    // Table training; fetch reads the old value on a same-index collision since there is no bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (train_en) begin
            table_q[r_idx] <= r_ctr_next;
        end
    end

    // Saturating performance counters; clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (stat_clr) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (r_valid) begin
            if (br_count != STAT_MAX) begin
                br_count <= br_count + STAT_W'(1);
            end
            if (mispredict && (miss_count != STAT_MAX)) begin
                miss_count <= miss_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_fetch_predictor.sv
// tb/tb_bht_fetch_predictor.sv - self-checking bench for bht_fetch_predictor
module tb_bht_fetch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        predict_en;
    logic        f_valid;
    logic [15:0] f_pc;
    logic [3:0]  f_opcode;
    logic [2:0]  f_ir_9_11;
    logic [1:0]  f_sel;
    logic        f_pred_taken;
    logic        r_valid;
    logic [15:0] r_pc;
    logic [2:0]  r_ir_9_11;
    logic [2:0]  r_cc;
    logic        r_pred_taken;
    logic        r_actual_taken;
    logic        r_mispredict;
    logic        stat_clr;
    logic [3:0]  br_count;
    logic [3:0]  miss_count;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ctr [16];
    int m_br;
    int m_miss;
    bit mon_on = 1'b0;

    bht_fetch_predictor #(
        .ENTRIES(16),
        .CTR_W  (2),
        .PC_W   (16),
        .STAT_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .predict_en    (predict_en),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .f_opcode      (f_opcode),
        .f_ir_9_11     (f_ir_9_11),
        .f_sel         (f_sel),
        .f_pred_taken  (f_pred_taken),
        .r_valid       (r_valid),
        .r_pc          (r_pc),
        .r_ir_9_11     (r_ir_9_11),
        .r_cc          (r_cc),
        .r_pred_taken  (r_pred_taken),
        .r_actual_taken(r_actual_taken),
        .r_mispredict  (r_mispredict),
        .stat_clr      (stat_clr),
        .br_count      (br_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic int exp_pred();
        if (!f_valid || f_opcode != 4'h0) return 0;
        if (f_ir_9_11 == 3'b111) return 1;
        if (f_ir_9_11 == 3'b000) return 0;
        if (!predict_en) return 0;
        return (m_ctr[m_idx(f_pc)] >= 2) ? 1 : 0;
    endfunction

    function automatic int exp_sel();
        if (!f_valid) return 0;
        if (f_opcode == 4'h0) return exp_pred();
        if (f_opcode == 4'hF) return 2;
        if (f_opcode == 4'hC) return 3;
        return 0;
    endfunction

    function automatic int exp_actual();
        return (r_valid && ((r_ir_9_11 & r_cc) != 3'b000)) ? 1 : 0;
    endfunction

    function automatic int exp_mis();
        return (r_valid && (exp_actual() != int'(r_pred_taken))) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_clock();
        int a;
        int m;
        int ix;
        if (rst) return;
        a  = exp_actual();
        m  = exp_mis();
        ix = m_idx(r_pc);
        if (r_valid && r_ir_9_11 != 3'b000 && r_ir_9_11 != 3'b111) begin
            if (a != 0) m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
            else        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
        end
        if (stat_clr) begin
            m_br   = 0;
            m_miss = 0;
        end else if (r_valid) begin
            m_br = (m_br < 15) ? m_br + 1 : 15;
            if (m != 0) m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic fetch(input logic v, input logic [15:0] pc, input logic [3:0] op, input logic [2:0] nzp);
        f_valid   = v;
        f_pc      = pc;
        f_opcode  = op;
        f_ir_9_11 = nzp;
    endtask

    task automatic resolve(input logic v, input logic [15:0] pc, input logic [2:0] nzp,
                           input logic [2:0] cc, input logic p);
        r_valid      = v;
        r_pc         = pc;
        r_ir_9_11    = nzp;
        r_cc         = cc;
        r_pred_taken = p;
    endtask

    // Every cycle the outputs are checked against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("mon_f_sel",          32'(f_sel),          32'(exp_sel()));
            chk("mon_f_pred_taken",   32'(f_pred_taken),   32'(exp_pred()));
            chk("mon_r_actual_taken", 32'(r_actual_taken), 32'(exp_actual()));
            chk("mon_r_mispredict",   32'(r_mispredict),   32'(exp_mis()));
            chk("mon_br_count",       32'(br_count),       32'(m_br));
            chk("mon_miss_count",     32'(miss_count),     32'(m_miss));
        end
    end

    logic [3:0] op_tab [8];

    initial begin
        op_tab[0] = 4'h0; op_tab[1] = 4'h1; op_tab[2] = 4'hF; op_tab[3] = 4'h0;
        op_tab[4] = 4'hC; op_tab[5] = 4'h0; op_tab[6] = 4'h5; op_tab[7] = 4'h0;

        rst        = 1'b1;
        predict_en = 1'b1;
        stat_clr   = 1'b0;
        fetch(1'b1, 16'h3000, 4'h0, 3'b010);
        resolve(1'b0, 16'h0000, 3'b000, 3'b000, 1'b0);
        model_reset();
        mon_on = 1'b1;
        tick();
        tick();

        // Reset state
        chk("reset_pred", 32'(f_pred_taken), 32'd0);
        chk("reset_sel",  32'(f_sel),        32'd0);
        chk("reset_br",   32'(br_count),     32'd0);
        chk("reset_miss", 32'(miss_count),   32'd0);

        // Resolution coincident with reset is dropped
        resolve(1'b1, 16'h3000, 3'b010, 3'b010, 1'b0);
        tick();
        rst = 1'b0;
        resolve(1'b0, 16'h3000, 3'b010, 3'b010, 1'b0);
        tick();
        chk("rst_train_drop_br", 32'(br_count),     32'd0);
        chk("rst_train_drop_pr", 32'(f_pred_taken), 32'd0);

        // Training 01 -> 10 -> 11
        resolve(1'b1, 16'h3000, 3'b010, 3'b010, 1'b0);
        #1;
        chk("train_mispredict", 32'(r_mispredict), 32'd1);
        tick();
        tick();
        resolve(1'b0, 16'h3000, 3'b010, 3'b010, 1'b0);
        #1;
        chk("train_sel",  32'(f_sel),      32'd1);
        chk("train_br",   32'(br_count),   32'd2);
        chk("train_miss", 32'(miss_count), 32'd2);

        // Saturation and hysteresis
        resolve(1'b1, 16'h3000, 3'b010, 3'b010, 1'b1);
        repeat (5) tick();
        resolve(1'b1, 16'h3000, 3'b010, 3'b100, 1'b1);
        tick();
        resolve(1'b0, 16'h3000, 3'b010, 3'b100, 1'b1);
        #1;
        chk("hyst_one_nt", 32'(f_pred_taken), 32'd1);
        resolve(1'b1, 16'h3000, 3'b010, 3'b100, 1'b1);
        tick();
        resolve(1'b0, 16'h3000, 3'b010, 3'b100, 1'b1);
        #1;
        chk("hyst_two_nt", 32'(f_pred_taken), 32'd0);

        // Static opcodes
        fetch(1'b1, 16'h3000, 4'hF, 3'b000);
        #1; chk("static_trap", 32'(f_sel), 32'd2);
        tick();
        fetch(1'b1, 16'h3000, 4'hC, 3'b000);
        #1; chk("static_jmp", 32'(f_sel), 32'd3);
        tick();
        fetch(1'b1, 16'h3000, 4'h0, 3'b111);
        #1; chk("static_br_111", 32'(f_sel), 32'd1);
        tick();
        fetch(1'b1, 16'h3000, 4'h0, 3'b000);
        #1; chk("static_br_000", 32'(f_sel), 32'd0);
        tick();
        fetch(1'b1, 16'h3000, 4'h0, 3'b010);
        resolve(1'b1, 16'h3000, 3'b010, 3'b010, 1'b0);
        tick();
        tick();
        resolve(1'b0, 16'h3000, 3'b010, 3'b010, 1'b0);
        predict_en = 1'b0;
        #1; chk("static_pred_dis", 32'(f_sel), 32'd0);
        tick();
        predict_en = 1'b1;
        #1; chk("static_pred_en", 32'(f_sel), 32'd1);
        tick();

        // Aliasing and same-cycle read/write: bring entry 0 back to 01
        resolve(1'b1, 16'h3000, 3'b010, 3'b100, 1'b1);
        tick();
        tick();
        resolve(1'b1, 16'h3020, 3'b010, 3'b010, 1'b0);
        #1; chk("alias_old", 32'(f_pred_taken), 32'd0);
        tick();
        resolve(1'b0, 16'h3020, 3'b010, 3'b010, 1'b0);
        #1; chk("alias_new", 32'(f_pred_taken), 32'd1);
        tick();

        // Statistics saturation and clear priority
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1; chk("stat_clr_idle", 32'(br_count), 32'd0);
        resolve(1'b1, 16'h3004, 3'b001, 3'b001, 1'b0);
        repeat (20) tick();
        resolve(1'b0, 16'h3004, 3'b001, 3'b001, 1'b0);
        #1;
        chk("stat_miss_sat", 32'(miss_count), 32'd15);
        chk("stat_br_sat",   32'(br_count),   32'd15);
        stat_clr = 1'b1;
        resolve(1'b1, 16'h3004, 3'b001, 3'b001, 1'b0);
        tick();
        stat_clr = 1'b0;
        resolve(1'b0, 16'h3004, 3'b001, 3'b001, 1'b0);
        #1;
        chk("stat_clr_br",   32'(br_count),   32'd0);
        chk("stat_clr_miss", 32'(miss_count), 32'd0);

        // Mixed vectors checked by the monitor against the model
        for (int i = 0; i < 24; i++) begin
            fetch((i % 5) != 0, 16'(16'h3000 + i * 2), op_tab[i % 8], 3'(i % 8));
            resolve((i % 3) != 2, 16'(16'h3000 + (i % 6) * 2), 3'((i * 3) % 8), 3'((i % 3) == 0 ? 3'b100 : ((i % 3) == 1 ? 3'b010 : 3'b001)), 1'((i / 2) % 2));
            predict_en = (i % 7) != 6;
            tick();
        end

        // Asynchronous reset assertion mid-run
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_br", 32'(br_count), 32'd0);
        tick();
        rst = 1'b0;
        resolve(1'b0, 16'h3000, 3'b010, 3'b010, 1'b0);
        tick();
        tick();

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
